// File: rtl/sincos_sched.sv
// Round-robin front end sharing one pipelined sincos core between NREQ requesters.
// A {valid,id} tag pipe tracks the core latency; result backpressure freezes the core via en.
module sincos_sched #(
    parameter  int W    = 27,
    parameter  int NREQ = 4,
    parameter  int LAT  = 27,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW   = $clog2(LAT + 2)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_angle,
    output logic [NREQ-1:0]     req_ready,
    output logic                cordic_en,
    output logic [W-1:0]        cordic_angle,
    input  logic [W-1:0]        cordic_sin,
    input  logic [W-1:0]        cordic_cos,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDW-1:0]      res_id,
    output logic [W-1:0]        res_sin,
    output logic [W-1:0]        res_cos,
    output logic [BW-1:0]       busy
);

    logic             v_reg  [LAT];
    logic [IDW-1:0]   id_reg [LAT];
    logic [IDW-1:0]   ptr_reg;
    logic [BW-1:0]    busy_reg;
    logic             stall;
    logic             issue_ok;
    logic             grant_any;
    logic [IDW-1:0]   gid;
    logic             handshake;
    logic             retire;

    // Results held back by the consumer keep the core frozen; during reset the
    // core keeps running so stale in-flight work drains out harmlessly.
    assign res_valid = v_reg[LAT-1] & ~reset;
    assign stall     = res_valid & ~res_ready;
    assign cordic_en = ~stall;
    assign issue_ok  = ~stall & ~reset;
    assign handshake = issue_ok & grant_any;
    assign retire    = res_valid & res_ready;

    // Search from ptr+1 upward with wrap; iterating offsets in descending order
    // lets the smallest offset win.
    always_comb begin
        logic [IDW:0] idx;
        gid       = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = {1'b0, ptr_reg} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NREQ))
                idx = idx - (IDW+1)'(NREQ);
            if (req_valid[idx[IDW-1:0]]) begin
                grant_any = 1'b1;
                gid       = idx[IDW-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = handshake & (gid == IDW'(gi));
        end
    endgenerate

    always_comb begin
        cordic_angle = '0;
        if (handshake)
            cordic_angle = req_angle[gid*W +: W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) begin
                v_reg[k]  <= 1'b0;
                id_reg[k] <= '0;
            end
        end else if (cordic_en) begin
            v_reg[0]  <= handshake;
            id_reg[0] <= gid;
            for (int k = 1; k < LAT; k++) begin
                v_reg[k]  <= v_reg[k-1];
                id_reg[k] <= id_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr_reg <= IDW'(NREQ - 1);
        else if (handshake)
            ptr_reg <= gid;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy_reg <= '0;
        else if (handshake && !retire)
            busy_reg <= busy_reg + 1'b1;
        else if (!handshake && retire)
            busy_reg <= busy_reg - 1'b1;
    end

    assign busy    = busy_reg;
    assign res_id  = id_reg[LAT-1];
    assign res_sin = cordic_sin;
    assign res_cos = cordic_cos;

endmodule

// File: tb/tb_sincos_sched.sv
// Randomized bench for sincos_sched: a stand-in pipelined core plus a queue-based
// reference that tracks issued ops by enabled-edge count.
module tb_sincos_sched;
    localparam int W    = 27;
    localparam int NREQ = 4;
    localparam int LAT  = 27;
    localparam int IDW  = 2;
    localparam int BW   = 5;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_angle;
    logic [NREQ-1:0]     req_ready;
    logic                cordic_en;
    logic [W-1:0]        cordic_angle;
    logic [W-1:0]        cordic_sin;
    logic [W-1:0]        cordic_cos;
    logic                res_valid;
    logic                res_ready;
    logic [IDW-1:0]      res_id;
    logic [W-1:0]        res_sin;
    logic [W-1:0]        res_cos;
    logic [BW-1:0]       busy;

    sincos_sched #(.W(W), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .cordic_en(cordic_en), .cordic_angle(cordic_angle),
        .cordic_sin(cordic_sin), .cordic_cos(cordic_cos),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_sin(res_sin), .res_cos(res_cos), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] sin_f(input logic [W-1:0] a);
        return a * 27'd5 + 27'd7;
    endfunction
    function automatic logic [W-1:0] cos_f(input logic [W-1:0] a);
        return a ^ 27'h5A5A5A5;
    endfunction

    // Stand-in core: LAT-deep angle pipeline advancing only on enabled edges.
    logic [W-1:0] core_pipe [LAT];
    always @(posedge clk) begin
        if (cordic_en) begin
            core_pipe[0] <= cordic_angle;
            for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
        end
    end
    assign cordic_sin = sin_f(core_pipe[LAT-1]);
    assign cordic_cos = cos_f(core_pipe[LAT-1]);

    typedef struct {
        int           id;
        logic [W-1:0] ang;
        int           c;
    } op_t;

    op_t q[$];
    int  en_cnt = 0;
    int  ptr    = NREQ - 1;
    int  n_cmp  = 0;
    int  n_bad  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare against the reference, advance the reference.
    task automatic run_cycle(input logic [NREQ-1:0] v, input logic rr, input logic rst,
                             input int fix0);
        logic         exp_rv;
        logic         exp_en;
        int           gid;
        logic         found;
        logic [W-1:0] exp_ang;
        @(negedge clk);
        req_valid = v;
        res_ready = rr;
        reset     = rst;
        for (int i = 0; i < NREQ; i++) req_angle[i*W +: W] = W'($urandom);
        if (fix0 >= 0) req_angle[0 +: W] = W'(fix0);
        #1;
        exp_rv = !rst && q.size() > 0 && (q[0].c + LAT == en_cnt);
        exp_en = !(exp_rv && !rr);
        found  = 1'b0;
        gid    = 0;
        if (exp_en && !rst) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && v[(ptr + k) % NREQ]) begin
                    found = 1'b1;
                    gid   = (ptr + k) % NREQ;
                end
            end
        end
        exp_ang = found ? req_angle[gid*W +: W] : '0;

        check("req_ready", 64'(req_ready), found ? 64'(1 << gid) : 64'd0);
        check("res_valid", 64'(res_valid), 64'(exp_rv));
        if (!rst) begin
            check("cordic_en", 64'(cordic_en), 64'(exp_en));
            check("cordic_angle", 64'(cordic_angle), 64'(exp_ang));
            check("busy", 64'(busy), 64'(q.size()));
        end
        if (exp_rv && res_valid === 1'b1) begin
            check("res_id", 64'(res_id), 64'(q[0].id));
            check("res_sin", 64'(res_sin), 64'(sin_f(q[0].ang)));
            check("res_cos", 64'(res_cos), 64'(cos_f(q[0].ang)));
        end

        if (rst) begin
            q.delete();
            ptr = NREQ - 1;
        end else begin
            if (exp_rv && rr) void'(q.pop_front());
            if (found) begin
                q.push_back('{id: gid, ang: exp_ang, c: en_cnt});
                ptr = gid;
            end
        end
        if (exp_en) en_cnt++;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_angle = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b1, 1'b1, -1);

        // Single op from requester 0 with angle 251, then drain.
        run_cycle(4'b0001, 1'b1, 1'b0, 251);
        for (int i = 0; i < 32; i++) run_cycle(4'b0000, 1'b1, 1'b0, -1);

        // All requesters contending continuously.
        for (int i = 0; i < 40; i++) run_cycle(4'b1111, 1'b1, 1'b0, -1);
        for (int i = 0; i < 30; i++) run_cycle(4'b0000, 1'b1, 1'b0, -1);

        // Fairness: requester 2 alone, then joined by requester 0.
        for (int i = 0; i < 10; i++) run_cycle(4'b0100, 1'b1, 1'b0, -1);
        for (int i = 0; i < 20; i++) run_cycle(4'b0101, 1'b1, 1'b0, -1);
        for (int i = 0; i < 30; i++) run_cycle(4'b0000, 1'b1, 1'b0, -1);

        // Backpressure: 5-cycle consumer stall when the first result appears.
        for (int i = 0; i < 27; i++) run_cycle(4'b1111, 1'b1, 1'b0, -1);
        for (int i = 0; i < 5; i++)  run_cycle(4'b1111, 1'b0, 1'b0, -1);
        for (int i = 0; i < 10; i++) run_cycle(4'b1111, 1'b1, 1'b0, -1);
        for (int i = 0; i < 35; i++) run_cycle(4'b0000, 1'b1, 1'b0, -1);

        // Reset mid-flight: three ops, reset at cycle 10, then all contend.
        for (int i = 0; i < 3; i++)  run_cycle(4'b1010, 1'b1, 1'b0, -1);
        for (int i = 3; i < 10; i++) run_cycle(4'b0000, 1'b1, 1'b0, -1);
        run_cycle(4'b0000, 1'b1, 1'b1, -1);
        for (int i = 0; i < 35; i++) run_cycle(i < 4 ? 4'b1111 : 4'b0000, 1'b1, 1'b0, -1);

        // Bubbles on cycles 0, 2, 5.
        for (int i = 0; i < 40; i++)
            run_cycle((i == 0 || i == 2 || i == 5) ? 4'b0010 : 4'b0000, 1'b1, 1'b0, -1);

        // Random valid patterns and consumer backpressure.
        for (int i = 0; i < 400; i++)
            run_cycle(4'($urandom), ($urandom_range(0, 9) < 7), 1'b0, -1);
        for (int i = 0; i < 60; i++) run_cycle(4'b0000, 1'b1, 1'b0, -1);

        check("drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
